// File: rtl/peak_readout_pkg.sv
// Shared types and defaults for the peak result readout path.
// Pixel extraction helper works on a zero-extended bus.
package peak_readout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CSUM
  } state_t;

  localparam int NP_DEF      = 10;
  localparam int PIX_NUM_DEF = 4;
  localparam int FRM_W_DEF   = 8;
  localparam int BUS_MAX     = 1024;
  localparam int WORD_MAX    = 64;

  function automatic logic [WORD_MAX-1:0] pix_get(
    input logic [BUS_MAX-1:0] bus,
    input int                 k,
    input int                 np
  );
    logic [BUS_MAX-1:0] sh;
    sh = bus >> (k * np);
    return sh[WORD_MAX-1:0];
  endfunction

endpackage

// File: rtl/result_dbuf.sv
// ACT/PEND result buffers with pend_full and sticky drop flag.
// refill tells the sequencer whether ACT gets new content on advance.
module result_dbuf
  import peak_readout_pkg::*;
#(
  parameter int NP      = NP_DEF,
  parameter int PIX_NUM = PIX_NUM_DEF
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [NP*PIX_NUM-1:0]   result,
  input  logic                    frame_done,
  input  logic                    busy,
  input  logic                    advance,
  output logic [NP*PIX_NUM-1:0]   act,
  output logic                    pend_full,
  output logic                    overflow,
  output logic                    refill
);

  logic [NP*PIX_NUM-1:0] pend;

  assign refill = pend_full | frame_done;

  // Load, promote or park incoming frames; drop when both slots busy.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      act       <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      overflow  <= 1'b0;
    end else if (!busy) begin
      if (frame_done) act <= result;
    end else if (advance) begin
      if (pend_full) begin
        act <= pend;
        if (frame_done) pend <= result;
        else pend_full <= 1'b0;
      end else if (frame_done) begin
        act <= result;
      end
    end else if (frame_done) begin
      if (!pend_full) begin
        pend      <= result;
        pend_full <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/peak_readout.sv
// Streams a snapshotted per-pixel peak vector one pixel per beat.
// Optional checksum beat: define PEAK_READOUT_CSUM_EN.
module peak_readout
  import peak_readout_pkg::*;
#(
  parameter int NP      = NP_DEF,
  parameter int PIX_NUM = PIX_NUM_DEF,
  parameter int IDX_W   = 2,
  parameter int FRM_W   = FRM_W_DEF
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic [NP*PIX_NUM-1:0] result,
  input  logic                  frame_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NP-1:0]         out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic [FRM_W-1:0]      out_frame,
  output logic                  out_first,
  output logic                  out_last,
`ifdef PEAK_READOUT_CSUM_EN
  output logic                  out_csum,
`endif
  output logic                  overflow
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(PIX_NUM - 1);

  state_t                 state, nstate;
  logic [IDX_W-1:0]       idx, nidx;
  logic [FRM_W-1:0]       frame, nframe;
  logic [NP*PIX_NUM-1:0]  act;
  logic                   pend_full;
  logic                   refill;
  logic                   busy, hs, at_last, advance;
  logic [NP-1:0]          pix;

  assign busy    = (state != IDLE);
  assign hs      = busy && out_ready;
  assign at_last = (idx == LAST);
  assign pix     = NP'(pix_get(BUS_MAX'(act), int'(idx), NP));

`ifdef PEAK_READOUT_CSUM_EN
  logic [NP-1:0] csum;

  // XOR of every pixel word in the active frame.
  always_comb begin
    csum = '0;
    for (int k = 0; k < PIX_NUM; k++)
      csum ^= NP'(pix_get(BUS_MAX'(act), k, NP));
  end

  assign advance = hs && (state == CSUM);
`else
  assign advance = hs && (state == SEND) && at_last;
`endif

  result_dbuf #(
    .NP      (NP),
    .PIX_NUM (PIX_NUM)
  ) u_dbuf (
    .clk        (clk),
    .res        (res),
    .result     (result),
    .frame_done (frame_done),
    .busy       (busy),
    .advance    (advance),
    .act        (act),
    .pend_full  (pend_full),
    .overflow   (overflow),
    .refill     (refill)
  );

  // Sequencer state, beat index and frame tag registers.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
      idx   <= '0;
      frame <= '0;
    end else begin
      state <= nstate;
      idx   <= nidx;
      frame <= nframe;
    end
  end

  // Next state: step pixels, then close the frame and refill or idle.
  always_comb begin
    nstate = state;
    nidx   = idx;
    nframe = frame;
    unique case (state)
      IDLE: begin
        if (frame_done) begin
          nstate = SEND;
          nidx   = '0;
        end
      end
      SEND: begin
        if (hs) begin
          if (!at_last) begin
            nidx = idx + IDX_W'(1);
          end else begin
`ifdef PEAK_READOUT_CSUM_EN
            nstate = CSUM;
`else
            nframe = frame + FRM_W'(1);
            nidx   = '0;
            nstate = refill ? SEND : IDLE;
`endif
          end
        end
      end
      CSUM: begin
        if (hs) begin
          nframe = frame + FRM_W'(1);
          nidx   = '0;
          nstate = refill ? SEND : IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Beat fields are driven only while a beat is offered.
  always_comb begin
    out_valid = busy;
    out_data  = '0;
    out_idx   = '0;
    out_frame = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
`ifdef PEAK_READOUT_CSUM_EN
    out_csum  = 1'b0;
`endif
    if (state == SEND) begin
      out_data  = pix;
      out_idx   = idx;
      out_frame = frame;
      out_first = (idx == '0);
`ifndef PEAK_READOUT_CSUM_EN
      out_last  = at_last;
`endif
    end
`ifdef PEAK_READOUT_CSUM_EN
    if (state == CSUM) begin
      out_data  = csum;
      out_frame = frame;
      out_last  = 1'b1;
      out_csum  = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_peak_readout.sv
// Randomized and directed checks of peak_readout against a
// queue-of-beats reference model.
module tb_peak_readout;

  localparam int NP    = 10;
  localparam int PIX   = 4;
  localparam int IDX_W = 2;
  localparam int FRM_W = 8;
`ifdef PEAK_READOUT_CSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              res = 1'b0;
  logic [NP*PIX-1:0] result = '0;
  logic              frame_done = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [NP-1:0]     out_data;
  logic [IDX_W-1:0]  out_idx;
  logic [FRM_W-1:0]  out_frame;
  logic              out_first;
  logic              out_last;
  logic              overflow;
`ifdef PEAK_READOUT_CSUM_EN
  logic              out_csum;
`endif

  peak_readout #(
    .NP      (NP),
    .PIX_NUM (PIX),
    .IDX_W   (IDX_W),
    .FRM_W   (FRM_W)
  ) dut (
    .clk        (clk),
    .res        (res),
    .result     (result),
    .frame_done (frame_done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_frame  (out_frame),
    .out_first  (out_first),
    .out_last   (out_last),
`ifdef PEAK_READOUT_CSUM_EN
    .out_csum   (out_csum),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] d;
    int            idx;
    int            tag;
    bit            first;
    bit            last;
    bit            cs;
  } beat_t;

  beat_t q[$];
  int    acc;
  bit    ovf;
  int    checks;
  int    errors;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [NP*PIX-1:0] rnd_res();
    logic [NP*PIX-1:0] r;
    for (int k = 0; k < PIX; k++)
      r[k*NP +: NP] = NP'($urandom);
    return r;
  endfunction

  function automatic int frames_in();
    int n = 0;
    foreach (q[i]) if (q[i].last) n++;
    return n;
  endfunction

  task automatic push_frame(input logic [NP*PIX-1:0] r);
    logic [NP-1:0] x;
    logic [NP-1:0] w;
    int            tag;
    x   = '0;
    tag = acc % (1 << FRM_W);
    for (int k = 0; k < PIX; k++) begin
      w = r[k*NP +: NP];
      x ^= w;
      q.push_back('{d: w, idx: k, tag: tag,
                    first: (k == 0),
                    last: (k == PIX-1) && !CS,
                    cs: 1'b0});
    end
    if (CS)
      q.push_back('{d: x, idx: 0, tag: tag,
                    first: 1'b0, last: 1'b1,
                    cs: 1'b1});
    acc++;
  endtask

  task automatic model(input bit fd,
                       input logic [NP*PIX-1:0] r,
                       input bit rdy);
    bit hs;
    bit done;
    int n;
    hs   = (q.size() > 0) && rdy;
    done = hs && q[0].last;
    n    = frames_in();
    if (hs) void'(q.pop_front());
    if (fd) begin
      if (n - (done ? 1 : 0) < 2) push_frame(r);
      else ovf = 1'b1;
    end
  endtask

  task automatic check_out();
    beat_t b;
    if (q.size() == 0) begin
      chk("valid", 64'(out_valid), 64'(0));
      chk("data",  64'(out_data),  64'(0));
      chk("idx",   64'(out_idx),   64'(0));
      chk("frame", 64'(out_frame), 64'(0));
      chk("first", 64'(out_first), 64'(0));
      chk("last",  64'(out_last),  64'(0));
    end else begin
      b = q[0];
      chk("valid", 64'(out_valid), 64'(1));
      chk("data",  64'(out_data),  64'(b.d));
      chk("idx",   64'(out_idx),   64'(b.idx));
      chk("frame", 64'(out_frame), 64'(b.tag));
      chk("first", 64'(out_first), 64'(b.first));
      chk("last",  64'(out_last),  64'(b.last));
`ifdef PEAK_READOUT_CSUM_EN
      chk("csum",  64'(out_csum),  64'(b.cs));
`endif
    end
    chk("ovf", 64'(overflow), 64'(ovf));
  endtask

  task automatic step(input bit fd,
                      input logic [NP*PIX-1:0] r,
                      input bit rdy);
    @(negedge clk);
    check_out();
    frame_done = fd;
    result     = r;
    out_ready  = rdy;
    model(fd, r, rdy);
    @(posedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, rnd_res(), 1'b1);
  endtask

  logic [NP*PIX-1:0] f1;
  logic [NP*PIX-1:0] f2;

  initial begin
    checks = 0;
    errors = 0;
    acc    = 0;
    ovf    = 1'b0;
    f1 = {10'd40, 10'd30, 10'd20, 10'd10};
    f2 = {10'h3FF, 10'h001, 10'h002, 10'h004};

    repeat (3) @(negedge clk);
    check_out();
    res = 1'b1;

    // single frame, ready always high
    step(1'b1, f1, 1'b1);
    drain(8);

    // same frame, ready pattern 1,0,0,1
    step(1'b1, f1, 1'b0);
    for (int i = 0; i < 24; i++)
      step(1'b0, rnd_res(), (i % 4 == 0) || (i % 4 == 3));
    drain(4);

    // frame 2 parked, frame 3 dropped
    step(1'b1, rnd_res(), 1'b0);
    step(1'b0, rnd_res(), 1'b1);
    step(1'b1, rnd_res(), 1'b0);
    step(1'b1, rnd_res(), 1'b0);
    drain(14);

    // frame_done coincident with last handshake
    step(1'b1, f2, 1'b1);
    for (int i = 1; i < PIX + (CS ? 1 : 0); i++)
      step(1'b0, rnd_res(), 1'b1);
    step(1'b1, f1, 1'b1);
    drain(10);

    // async reset mid-frame
    step(1'b1, rnd_res(), 1'b1);
    step(1'b0, rnd_res(), 1'b1);
    frame_done = 1'b0;
    #2 res = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  64'(out_data),  64'(0));
    chk("rst_idx",   64'(out_idx),   64'(0));
    chk("rst_ovf",   64'(overflow),  64'(0));
    q.delete();
    acc = 0;
    ovf = 1'b0;
    repeat (2) @(negedge clk);
    res = 1'b1;
    step(1'b1, f1, 1'b1);
    drain(8);

    // back-to-back frames through the tag wrap
    for (int i = 0; i < 260 * (PIX + (CS ? 1 : 0)); i++)
      step((i % (PIX + (CS ? 1 : 0))) == 0, rnd_res(), 1'b1);
    drain(10);

    // random traffic
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 5) == 0, rnd_res(),
           $urandom_range(0, 9) < 7);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peak_readout.md
Name: peak_readout

Overview:
- Reader end of the histogram builder's packed per-pixel peak result bus.
- Snapshots the `Np*PIXEL_NUM_PER_RAM` result vector when a frame is reported done, then streams it one pixel per beat over a valid/ready interface toward the host/packetizer.
- Double-buffered so a new frame can arrive while the previous one is still draining.
- Sits between the histogram builder's result output and the readout link.

Parameters:
- NP, default 10, bits per pixel result (matches `Np`).
- PIX_NUM, default 4, pixels per RAM bank (matches `PIXEL_NUM_PER_RAM`).
- IDX_W, default 2, pixel index width; equals clog2(PIX_NUM), minimum 1.
- FRM_W, default 8, frame tag counter width.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  asynchronous active-low reset.
- result  in  NP*PIX_NUM  packed peak results; pixel k occupies bits [k*NP +: NP].
- frame_done  in  1  single-cycle pulse; result is valid in the same cycle.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  NP  pixel peak value.
- out_idx  out  IDX_W  pixel index of the current beat.
- out_frame  out  FRM_W  frame tag of the beat.
- out_first  out  1  first beat of a frame.
- out_last  out  1  last beat of a frame.
- overflow  out  1  sticky: a frame was dropped.

Behaviour:
- Reset (res low, async): every output, both buffers, the index, the frame counter and overflow go to 0. State is IDLE.
- Storage: ACT buffer (being sent) and PEND buffer (waiting), plus a pend_full flag.
- States:
  - IDLE: out_valid=0. On frame_done, load result into ACT, set idx=0, go to SEND. out_valid rises the next cycle, so latency is 1 cycle.
  - SEND: out_valid=1. out_data=ACT[idx], out_idx=idx, out_first=(idx==0), out_last=(idx==PIX_NUM-1).
- Beat acceptance:
  - A handshake is out_valid&&out_ready. On a handshake, idx increments.
  - With valid high and ready low, every out_* signal holds stable.
- Last handshake (idx==PIX_NUM-1):
  - frame counter increments, wrapping modulo 2^FRM_W.
  - If pend_full: move PEND into ACT, clear pend_full, set idx=0, stay in SEND. No bubble cycle.
  - Else if frame_done in the same cycle: load result directly into ACT, idx=0, stay in SEND. No bubble cycle.
  - Else: go to IDLE.
- frame_done during SEND (other than the direct-load case above):
  - If pend_full=0: load result into PEND and set pend_full.
  - If pend_full=1 and this is not the last handshake: drop the frame, set overflow=1. It stays set until reset.
  - If pend_full=1 and this is the last handshake: PEND moves to ACT, the new result goes to PEND, pend_full stays 1, no overflow.
- out_frame is the count of frames completed before the current one; the first frame after reset is tagged 0.
- Result values are not interpreted. Width NP passes straight through.
- When PIX_NUM=1, out_first and out_last are both 1 on every beat.

Optional Feature:
- Macro: PEAK_READOUT_CSUM_EN.
- Enabled:
  - After pixel PIX_NUM-1, one extra beat is sent: out_data = XOR of all PIX_NUM words of ACT, out_idx=0, and out_csum=1 (an extra output port that exists only with the macro).
  - out_last moves from the last pixel beat to the checksum beat.
  - Frame advance and buffer swap happen on the checksum handshake instead of the last pixel handshake.
- Disabled: no checksum beat and no out_csum port; behaviour is exactly as above.

Decomposition:
- Shared package `peak_readout_pkg`:
  - state enum {IDLE, SEND, CSUM}.
  - localparam defaults for NP, PIX_NUM and FRM_W, aligned with `parametersSiFH.vh`.
  - a function to extract pixel k from the packed bus.
- One natural sub-module, `result_dbuf`: the ACT/PEND register pair with pend_full, load/promote controls and overflow detection. The FSM and beat counter stay in the top level.

Test Plan:
- Reset, then one frame_done with result={40,30,20,10} (pixels 3..0), out_ready=1 → beats data 10,20,30,40; idx 0..3; first on beat 0, last on beat 3; frame tag 0; back to IDLE.
- Same frame with out_ready toggling 1,0,0,1,… → no lost or duplicated beats; out_* stable during every stall.
- Second frame_done mid-drain, then a third before the first finishes → frame 2 streams immediately after frame 1 with no gap; the third frame is dropped and overflow=1.
- frame_done coincident with the last handshake and PEND empty → next cycle out_data = the new pixel 0, out_first=1, out_frame=1.
- 256 back-to-back frames → out_frame wraps 255→0 with no overflow.
- Assert res mid-frame → outputs 0 asynchronously; after release, the next frame_done restarts at idx 0, frame tag 0.
- PEAK_READOUT_CSUM_EN set with result={0x3FF,0x001,0x002,0x004} → fifth beat out_data=0x3F8, out_csum=1, out_last=1.
